viterbi_ber_monitor: RTL
========================

Name: viterbi_ber_monitor

Overview:
- In-order scoreboard placed downstream of the Viterbi decoder in the tx/rx test harness.
- Captures every information bit entering the convolutional encoder and compares it with the decoder output stream.
- Reports bit count, error count, longest error run and first-bit latency.
- Flags FIFO overflow/underflow, so channel error-injection runs produce a measurable post-decoding BER without bench-side bookkeeping.

Parameters:
- DEPTH, 64, reference FIFO depth in bits; power of 2, minimum 4.
- SKIP, 0, number of leading decoder output bits discarded (decoder start-up/flush bits); these bits pop nothing.
- CW, 32, width of the bit, error and run counters.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- clear_i  input  1  synchronous clear; same effect as reset
- ref_valid_i  input  1  encoder input bit valid (driven from enable_encoder_i)
- ref_bit_i  input  1  encoder input bit
- dec_valid_i  input  1  decoder output bit valid
- dec_bit_i  input  1  decoder output bit
- bit_ct_o  output  CW  compared bits, saturating
- err_ct_o  output  CW  mismatched bits, saturating
- run_max_o  output  CW  longest run of consecutive mismatches
- first_lat_o  output  16  cycles from first accepted ref bit to first compared bit, saturating
- err_o  output  1  one-cycle pulse per mismatch
- state_o  output  2  IDLE=0, SKIP=1, RUN=2, FAULT=3
- ovf_o  output  1  sticky overflow flag
- udf_o  output  1  sticky underflow flag

Behaviour:
- Reset priority: rst low at a clock edge, then clear_i high, has priority over everything. Result: all outputs 0, FIFO empty, skip/run/latency counters 0, state IDLE. Reset mid-run discards FIFO contents.
- FIFO: ref_valid_i pushes ref_bit_i at the tail. Head is sampled at cycle start. There is no bypass: a bit pushed in cycle t can be popped at t+1 at the earliest.
- Occupancy: count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push when full with no pop: push dropped, ovf_o set, state goes to FAULT.
- Push and pop in the same cycle when full: both happen and occupancy is unchanged.
- IDLE:
  - Left on the first cycle in which ref_valid_i or dec_valid_i is high.
  - Next state is SKIP if SKIP>0, else RUN.
  - A dec_valid_i in the exit cycle is handled as in the destination state.
  - The latency counter starts on the first accepted ref_valid_i.
- SKIP:
  - Each dec_valid_i increments skip_ct and pops nothing.
  - When skip_ct reaches SKIP, go to RUN.
  - Pushes continue normally.
- RUN, dec_valid_i with FIFO non-empty:
  - Pop the head and compare it with dec_bit_i.
  - bit_ct_o increments next cycle.
  - On mismatch: err_ct_o increments next cycle, err_o pulses next cycle, cur_run increments.
  - On match: cur_run clears to 0.
  - run_max_o takes max(run_max_o, new cur_run) in the same update.
- RUN, dec_valid_i with FIFO empty (including a same-cycle push): udf_o set, no counter change, state goes to FAULT.
- first_lat_o: increments every cycle after the first ref push until the first RUN pop, then freezes. Latency of the first pop equals the value shown.
- FAULT:
  - Sticky until reset or clear.
  - Counters freeze.
  - Pushes and pops are ignored.
  - err_o stays 0.
- Counters: all saturate at all-ones and never wrap. cur_run saturates too.
- Output timing: all outputs registered; counter and err_o latency is 1 cycle after the dec_valid_i cycle.

Decomposition:
- Package viterbi_mon_pkg holds:
  - state enum (IDLE, SKIP, RUN, FAULT);
  - a saturating-increment function parameterised by width;
  - the constant LAT_W=16.
- Sub-module bit_fifo (parameter DEPTH) holds the 1-bit synchronous FIFO with push, pop, full, empty and head.
- Counters and the state machine stay in the top module.

Test Plan:
- Loopback, SKIP=0:
  - Stimulus: 100 ref bits; the same bits presented on dec with a 5-cycle delay.
  - Required: bit_ct_o=100, err_ct_o=0, run_max_o=0, first_lat_o=5, state RUN.
- Injected errors:
  - Stimulus: flip decoded bits 10, 11, 12 and 50 of 100.
  - Required: err_ct_o=4, run_max_o=3, err_o pulses exactly 4 times, each 1 cycle after the bad bit.
- SKIP=3:
  - Stimulus: 3 garbage dec bits precede the delayed loopback of 20 ref bits.
  - Required: state passes SKIP then RUN, bit_ct_o=20, err_ct_o=0.
- Overflow, DEPTH=4:
  - Stimulus: 5 ref pushes with no dec.
  - Required: ovf_o=1, state=FAULT; further dec_valid_i leaves bit_ct_o=0.
- Underflow:
  - Stimulus: dec_valid_i in the same cycle as the first ref push.
  - Required: udf_o=1, state=FAULT, bit_ct_o=0.
- Clear and reset:
  - Stimulus: clear_i mid-run after 30 bits, then a 10-bit loopback; separately, rst low for 1 cycle mid-run.
  - Required: after clear, all counters read 10/0 and flags 0; after rst, all outputs are 0 on the next edge.

Source files
------------

// File: rtl/viterbi_mon_pkg.sv
// Shared types and helpers for the Viterbi BER monitor.
// Holds the monitor state encoding and saturating-increment arithmetic.
package viterbi_mon_pkg;

  localparam int LAT_W = 16;
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } mon_state_e;

  // Width-generic saturating +1; callers truncate to their own width w.
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int               w
  );
    logic [SAT_W-1:0] lim;
    if (w >= SAT_W)
      lim = '1;
    else
      lim = (SAT_W'(1) << w) - SAT_W'(1);
    return (v >= lim) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/viterbi_ber_monitor_bit_fifo.sv
// 1-bit synchronous FIFO holding reference bits awaiting comparison.
// Head is a plain read of the stored word: no same-cycle bypass.
module bit_fifo #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic push_bit,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_q] <= push_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= wr_q + AW'(1);
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/viterbi_ber_monitor.sv
// In-order scoreboard comparing encoder input bits with decoder output.
// Reports bit/error counts, longest error run and first-bit latency.
module viterbi_ber_monitor
  import viterbi_mon_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SKIP  = 0,
  parameter int CW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  output logic [CW-1:0]    bit_ct_o,
  output logic [CW-1:0]    err_ct_o,
  output logic [CW-1:0]    run_max_o,
  output logic [LAT_W-1:0] first_lat_o,
  output logic             err_o,
  output logic [1:0]       state_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam int SKW = $clog2(SKIP + 2);
  localparam mon_state_e EXIT_ST =
    (SKIP > 0) ? ST_SKIP : ST_RUN;

  mon_state_e state_q;
  mon_state_e state_d;
  mon_state_e eff;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic leave_idle;
  logic act_run;
  logic act_skip;
  logic act_live;
  logic push;
  logic pop;
  logic ovf_hit;
  logic udf_hit;
  logic skip_hit;
  logic skip_done;
  logic mis;
  logic lat_tick;

  logic [SKW-1:0]   skip_ct_q;
  logic [SKW-1:0]   skip_nxt;
  logic [CW-1:0]    bit_ct_q;
  logic [CW-1:0]    err_ct_q;
  logic [CW-1:0]    cur_run_q;
  logic [CW-1:0]    run_max_q;
  logic [CW-1:0]    bit_inc;
  logic [CW-1:0]    err_inc;
  logic [CW-1:0]    run_nxt;
  logic [LAT_W-1:0] lat_q;
  logic [LAT_W-1:0] lat_inc;
  logic             lat_on_q;
  logic             lat_done_q;
  logic             err_q;
  logic             ovf_q;
  logic             udf_q;

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear_i),
    .push     (push),
    .pop      (pop),
    .push_bit (ref_bit_i),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // The IDLE exit cycle already behaves as the destination state.
  assign leave_idle = (state_q == ST_IDLE) &&
                      (ref_valid_i || dec_valid_i);
  assign eff        = leave_idle ? EXIT_ST : state_q;

  assign skip_nxt = skip_ct_q + SKW'(1);
  assign mis      = fifo_head ^ dec_bit_i;
  assign bit_inc  = CW'(sat_inc(SAT_W'(bit_ct_q), CW));
  assign err_inc  = CW'(sat_inc(SAT_W'(err_ct_q), CW));
  assign run_nxt  = CW'(sat_inc(SAT_W'(cur_run_q), CW));
  assign lat_inc  = LAT_W'(sat_inc(SAT_W'(lat_q), LAT_W));
  assign lat_tick = lat_on_q && !lat_done_q && act_live;

  always_ff @(posedge clk) begin
    if (!rst || clear_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = eff;
    if (ovf_hit || udf_hit)
      state_d = ST_FAULT;
    else if (skip_done)
      state_d = ST_RUN;
  end

  always_comb begin
    act_run   = 1'b0;
    act_skip  = 1'b0;
    act_live  = 1'b0;
    unique case (eff)
      ST_RUN: begin
        act_run  = 1'b1;
        act_live = 1'b1;
      end
      ST_SKIP: begin
        act_skip = 1'b1;
        act_live = 1'b1;
      end
      ST_FAULT: act_live = 1'b0;
      ST_IDLE:  act_live = 1'b0;
    endcase
    pop       = act_run && dec_valid_i && !fifo_empty;
    udf_hit   = act_run && dec_valid_i && fifo_empty;
    push      = act_live && ref_valid_i &&
                (!fifo_full || pop);
    ovf_hit   = act_live && ref_valid_i &&
                fifo_full && !pop;
    skip_hit  = act_skip && dec_valid_i;
    skip_done = skip_hit && (skip_nxt == SKW'(SKIP));
  end

  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      skip_ct_q  <= '0;
      bit_ct_q   <= '0;
      err_ct_q   <= '0;
      cur_run_q  <= '0;
      run_max_q  <= '0;
      lat_q      <= '0;
      lat_on_q   <= 1'b0;
      lat_done_q <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (ovf_hit)
        ovf_q <= 1'b1;
      if (udf_hit)
        udf_q <= 1'b1;
      if (skip_hit)
        skip_ct_q <= skip_nxt;
      if (push)
        lat_on_q <= 1'b1;
      if (lat_tick)
        lat_q <= lat_inc;
      if (pop) begin
        lat_done_q <= 1'b1;
        bit_ct_q   <= bit_inc;
        if (mis) begin
          err_ct_q  <= err_inc;
          err_q     <= 1'b1;
          cur_run_q <= run_nxt;
          if (run_nxt > run_max_q)
            run_max_q <= run_nxt;
        end else begin
          cur_run_q <= '0;
        end
      end
    end
  end

  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign run_max_o   = run_max_q;
  assign first_lat_o = lat_q;
  assign err_o       = err_q;
  assign state_o     = state_q;
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;

endmodule
